// File: rtl/sram_like_ot_ctrl_pkg.sv
// Shared CPU definitions for the SRAM-like bus controllers.
// Contents:
//   CPU_OT/CPU_TW/CPU_AW/CPU_DW - default outstanding depth and field widths
//   sram_req_t                  - one bus request beat (wr, size, addr, wdata)
//   tag_entry_t                 - one in-flight tag queue entry (tag, discard)
//   ptr_w()                     - pointer width for a queue of a given depth
package cpu_defs;

  localparam int CPU_OT = 4;
  localparam int CPU_TW = 4;
  localparam int CPU_AW = 32;
  localparam int CPU_DW = 32;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [CPU_AW-1:0] addr;
    logic [CPU_DW-1:0] wdata;
  } sram_req_t;

  typedef struct packed {
    logic [CPU_TW-1:0] tag;
    logic              discard;
  } tag_entry_t;

  // A depth-1 queue still needs a 1-bit pointer; it simply never moves.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_like_ot_ctrl_ot_fifo.sv
// ot_fifo: in-flight tag queue for sram_like_ot_ctrl.
// Ports:
//   clk, resetn                 - clock, synchronous active-low reset
//   push, push_tag, push_discard - enqueue one entry
//   pop                         - dequeue the head entry
//   flush                       - mark every stored entry as discard
//   head_tag, head_discard      - current head entry
//   full, empty, count          - occupancy
module ot_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int TW    = 4,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [TW-1:0] push_tag,
  input  logic          push_discard,
  input  logic          pop,
  input  logic          flush,
  output logic [TW-1:0] head_tag,
  output logic          head_discard,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [TW-1:0]    tag_mem_r [DEPTH];
  logic [DEPTH-1:0] disc_r;
  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;

  // Pointers wrap modulo DEPTH (also correct for DEPTH == 1).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) begin
      n = PW'(0);
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_r  <= PW'(0);
      rptr_r  <= PW'(0);
      count_r <= CW'(0);
    end else begin
      if (push) wptr_r <= ptr_inc(wptr_r);
      if (pop)  rptr_r <= ptr_inc(rptr_r);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Discard flags: flush marks everything; a slot written this cycle takes
  // the caller's discard value, which is already 1 when flush is active.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      disc_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) disc_r[i] <= 1'b1;
        if (push && (wptr_r == PW'(i))) disc_r[i] <= push_discard;
      end
    end
  end

  // Tag storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (push) tag_mem_r[wptr_r] <= push_tag;
  end

  assign head_tag     = tag_mem_r[rptr_r];
  assign head_discard = disc_r[rptr_r];
  assign full         = (count_r == CW'(DEPTH));
  assign empty        = (count_r == CW'(0));
  assign count        = count_r;

endmodule

// File: rtl/sram_like_ot_ctrl.sv
// sram_like_ot_ctrl: multi-outstanding SRAM-like bus request controller.
// Ports:
//   clk, resetn                     - clock, synchronous active-low reset
//   need_req, req_tag, req_wr, req_size, req_addr, req_wdata
//                                   - core request, held until accepted
//   flush                           - drop all in-flight responses
//   accept, busy                    - core handshake status
//   rsp_valid, rsp_tag, rsp_rdata   - zero-latency response to the core
//   outstanding, proto_err          - in-flight count, sticky stray data_ok
//   req, wr, size, addr, wdata      - bus request
//   addr_ok, data_ok, rdata         - bus handshake and read data
module sram_like_ot_ctrl
  import cpu_defs::*;
#(
  parameter int OT   = CPU_OT,
  parameter int TW   = CPU_TW,
  parameter int AW   = CPU_AW,
  parameter int DW   = CPU_DW,
  localparam int CW  = $clog2(OT + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          need_req,
  input  logic [TW-1:0] req_tag,
  input  logic          req_wr,
  input  logic [1:0]    req_size,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic          flush,
  output logic          accept,
  output logic          busy,
  output logic          rsp_valid,
  output logic [TW-1:0] rsp_tag,
  output logic [DW-1:0] rsp_rdata,
  output logic [CW-1:0] outstanding,
  output logic          proto_err,
  output logic          req,
  output logic          wr,
  output logic [1:0]    size,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic          addr_ok,
  input  logic          data_ok,
  input  logic [DW-1:0] rdata
);

  logic [TW-1:0] last_tag_r;
  logic          last_valid_r;
  logic          proto_err_r;

  logic          dup_s;
  logic          req_s;
  logic          accept_s;
  logic          pop_s;
  logic          busy_s;
  logic [TW-1:0] head_tag_s;
  logic          head_discard_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;

  // Handshake decode. While in reset nothing is pushed or popped, and req
  // and busy follow need_req alone.
  always_comb begin
    dup_s = last_valid_r & (req_tag == last_tag_r);
    if (resetn) begin
      // full_s is outstanding==OT; a pop this cycle does not free the slot
      // until the next cycle.
      req_s    = need_req & ~full_s & ~dup_s;
      accept_s = req_s & addr_ok;
      pop_s    = data_ok & ~empty_s;
      busy_s   = (need_req & ~dup_s & ~accept_s) | (~empty_s & ~head_discard_s);
    end else begin
      req_s    = need_req;
      accept_s = 1'b0;
      pop_s    = 1'b0;
      busy_s   = need_req;
    end
  end

  ot_fifo #(
    .DEPTH (OT),
    .TW    (TW)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push         (accept_s),
    .push_tag     (req_tag),
    .push_discard (flush),
    .pop          (pop_s),
    .flush        (flush),
    .head_tag     (head_tag_s),
    .head_discard (head_discard_s),
    .full         (full_s),
    .empty        (empty_s),
    .count        (count_s)
  );

  // Duplicate-suppression tag and sticky protocol error. An accept wins
  // over a coincident flush so the held request is not re-issued.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_valid_r <= 1'b0;
      last_tag_r   <= TW'(0);
      proto_err_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        last_valid_r <= 1'b1;
        last_tag_r   <= req_tag;
      end else if (flush) begin
        last_valid_r <= 1'b0;
      end else if (need_req && (req_tag != last_tag_r)) begin
        last_valid_r <= 1'b0;
      end else begin
        last_valid_r <= last_valid_r;
      end
      proto_err_r <= proto_err_r | (data_ok & empty_s);
    end
  end

  // The head's discard flag is read before this cycle's flush takes
  // effect, so a response popped with flush still reaches the core.
  assign rsp_valid   = pop_s & ~head_discard_s;
  assign rsp_tag     = head_tag_s;
  assign rsp_rdata   = rdata;
  assign accept      = accept_s;
  assign busy        = busy_s;
  assign outstanding = count_s;
  assign proto_err   = proto_err_r;

  assign req   = req_s;
  assign wr    = req_wr;
  assign size  = req_size;
  assign addr  = req_addr;
  assign wdata = req_wdata;

endmodule

// File: doc/sram_like_ot_ctrl.md
SRAM_LIKE_OT_CTRL -- requirements
Module: sram_like_ot_ctrl

Interface
REQ-001 SHALL take parameters: OT, default 4, maximum outstanding requests (power of 2, 1..8); TW, default 4, request tag width; AW, default 32, address width; DW, default 32, data width.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have ports need_req (in, 1), req_tag (in, TW), req_wr (in, 1), req_size (in, 2), req_addr (in, AW), req_wdata (in, DW): the core-side request, held stable while need_req=1 and not accepted.
REQ-005 SHALL have port flush, input, 1: discard all in-flight responses.
REQ-006 SHALL have ports accept (out, 1), busy (out, 1), rsp_valid (out, 1), rsp_tag (out, TW), rsp_rdata (out, DW), outstanding (out, clog2(OT+1)), proto_err (out, 1).
REQ-007 SHALL have bus ports req, wr (out, 1), size (out, 2), addr (out, AW), wdata (out, DW), addr_ok, data_ok (in, 1), rdata (in, DW).

Function
REQ-008 SHALL drive wr/size/addr/wdata combinationally from req_wr/req_size/req_addr/req_wdata.
REQ-009 SHALL assert req = need_req & (outstanding<OT) & ~dup, where dup = last_valid & (req_tag==last_tag).
REQ-010 SHALL assert accept = req & addr_ok; on accept, last_tag<=req_tag, last_valid<=1, and (tag, discard=flush) pushed to tag FIFO.
REQ-011 SHALL clear last_valid on flush, or when need_req=1 and req_tag!=last_tag; a new tag is therefore requestable in its first cycle.
REQ-012 SHALL assert busy = (need_req & ~dup & ~accept) | (outstanding!=0 & head entry not discard).
REQ-013 SHALL on data_ok with non-empty FIFO pop the head; rsp_valid=data_ok & ~head.discard, rsp_tag=head.tag, rsp_rdata=rdata, same cycle (zero latency).
REQ-014 SHALL treat data_ok with empty FIFO as protocol violation: no pop, rsp_valid=0, proto_err set sticky until reset.
REQ-015 SHALL on flush set discard on every FIFO entry; an entry popped in the same cycle as flush still produces rsp_valid (response precedes flush).
REQ-016 SHALL handle accept and data_ok in the same cycle as push+pop, outstanding unchanged; data_ok never matches a request accepted in the same cycle.
REQ-017 SHALL keep req low at outstanding==OT even if data_ok pops that cycle (no bypass); req may rise the next cycle.
REQ-018 SHALL keep responses in issue order (FIFO); pointers wrap modulo OT.

Reset
REQ-019 SHALL on resetn=0 clear FIFO pointers, outstanding=0, last_valid=0, proto_err=0; rsp_valid=0, accept=0, busy=need_req-dependent only, req=need_req.
REQ-020 SHALL on reset mid-operation abandon all in-flight entries; bus-side reset is the system's responsibility.

Structure
REQ-021 SHALL place sram_req_t (wr, size, addr, wdata) and tag_entry_t (tag, discard) typedefs in the shared cpu_defs package.
REQ-022 SHALL implement the tag/discard queue as one sub-module ot_fifo (depth OT, push, pop, flush-marks-all, full, empty, count).
REQ-023 SHALL be a drop-in superset of the single-outstanding handshake: OT=1 with req_tag=unique_id reproduces its behaviour.

Verification
REQ-024 Single read: need_req=1, tag=3, addr_ok cycle 1, data_ok cycle 3, rdata=0xDEADBEEF -> accept cycle 1, req low cycles 2-3, rsp_valid cycle 3 with tag=3, rdata=0xDEADBEEF, outstanding 1->0.
REQ-025 Fill: OT=4, tags 0..4 back-to-back, addr_ok always 1, no data_ok -> 4 accepts, req=0 at outstanding=4; first data_ok pops tag 0, req re-asserts next cycle for tag 4.
REQ-026 Flush: 3 outstanding (tags 1,2,3), flush cycle 5, data_ok cycles 6-8 -> rsp_valid=0 all three, outstanding reaches 0, busy low by cycle 9.
REQ-027 Flush coincident with data_ok of tag 1 -> tag 1 rsp_valid=1; tags 2,3 discarded; accept in same cycle stored as discard.
REQ-028 Stray data_ok with outstanding=0 -> proto_err=1 held, rsp_valid=0, outstanding stays 0; resetn=0 clears proto_err.
REQ-029 Duplicate suppression: need_req held with tag=7 after accept -> req=0 until tag changes to 8, req=1 same cycle.
